// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO write/read controllers: gray-code
// conversion and pointer width derivation.
package fifo_pkg;

    // Pointer carries one extra wrap bit on top of the RAM address.
    function automatic int ptr_width_of(input int addr_width);
        return addr_width + 1;
    endfunction

    // Width of an index that selects one of n items (at least one bit).
    function automatic int idx_width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Callers zero-extend into 32 bits and truncate the result, so one
    // pair of functions serves every pointer width up to 32.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after rr_ptr,
// wrapping modulo N, using a double-width masked priority search.
module rr_arbiter
    import fifo_pkg::*;
#(
    parameter int N  = 4,
    localparam int IW = idx_width_of(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] winner,
    output logic          any
);

    logic [2*N-1:0] dreq;
    logic [2*N-1:0] masked;

    // Unroll the request vector twice and mask off everything below rr_ptr
    // so that a plain lowest-index search implements the wrap-around.
    always_comb begin
        dreq   = {req, req};
        masked = '0;
        for (int i = 0; i < 2 * N; i++) begin
            masked[i] = dreq[i] && (i >= int'(rr_ptr));
        end
    end

    // Lowest set bit of the masked vector, folded back into 0..N-1.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!any && masked[i]) begin
                any    = 1'b1;
                winner = IW'(i % N);
            end
        end
    end

    // One-hot grant decoded from the winning index.
    always_comb begin
        gnt = '0;
        for (int j = 0; j < N; j++) begin
            gnt[j] = any && (winner == IW'(j));
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller of the async FIFO (wclk domain). Arbitrates the
// single RAM write port among NUM_REQ requesters, owns the binary/gray
// write pointer and derives full, almost-full and occupancy from the read
// pointer already synchronised into wclk.
//
// Handshake: req[i] is valid, gnt[i] is ready; a write happens in any
// cycle where req[i] & gnt[i]. A requester holds req and its data slice
// stable until granted, may drop req before a grant (no write), and may
// keep req high for zero-wait back-to-back writes. gnt is combinational
// from req in the same cycle and is never asserted while wfull is set or
// wrst_n is low.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int AFULL_THRESH = 2,
    localparam int PTR_WIDTH   = ptr_width_of(ADDR_WIDTH)
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic [PTR_WIDTH-1:0]          wq2_rptr,
    output logic [PTR_WIDTH-1:0]          wptr,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_waddr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    output logic                          wfull,
    output logic                          walmost_full,
    output logic [PTR_WIDTH-1:0]          wr_count
);

    localparam int IW = idx_width_of(NUM_REQ);
    localparam logic [PTR_WIDTH:0] DEPTH_W  = (PTR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [PTR_WIDTH:0] THRESH_W = (PTR_WIDTH+1)'(AFULL_THRESH);

    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        winner;
    logic [NUM_REQ-1:0]   arb_gnt;
    logic                 arb_any;
    logic                 grant_en;

    logic [PTR_WIDTH-1:0] wbin;
    logic [PTR_WIDTH-1:0] wbin_next;
    logic [PTR_WIDTH-1:0] wgray_next;
    logic [PTR_WIDTH-1:0] rbin;
    logic [PTR_WIDTH-1:0] count_next;
    logic [PTR_WIDTH:0]   free_next;
    logic                 full_next;
    logic                 afull_next;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req    (req),
        .rr_ptr (rr_ptr),
        .gnt    (arb_gnt),
        .winner (winner),
        .any    (arb_any)
    );

    // Grants are suppressed while full and while reset is held, so no write
    // can ever overflow the RAM and nothing leaks out during reset.
    assign grant_en  = wrst_n && !wfull;
    assign gnt       = grant_en ? arb_gnt : '0;
    assign mem_we    = grant_en && arb_any;
    assign mem_waddr = wbin[ADDR_WIDTH-1:0];

    // Steer the granted requester's payload onto the RAM data bus.
    always_comb begin
        mem_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mem_wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state pointer, occupancy and flag terms; a write and a read
    // pointer change in the same cycle both fold in here.
    always_comb begin
        wbin_next  = wbin + PTR_WIDTH'(mem_we);
        wgray_next = PTR_WIDTH'(bin2gray(32'(wbin_next)));
        rbin       = PTR_WIDTH'(gray2bin(32'(wq2_rptr)));
        count_next = wbin_next - rbin;
        free_next  = DEPTH_W - {1'b0, count_next};
        afull_next = (free_next <= THRESH_W);
        full_next  = (wgray_next == {~wq2_rptr[PTR_WIDTH-1:PTR_WIDTH-2],
                                     wq2_rptr[PTR_WIDTH-3:0]});
    end

    // Write pointer and registered status flags.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wr_count     <= '0;
        end else begin
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wfull        <= full_next;
            walmost_full <= afull_next;
            wr_count     <= count_next;
        end
    end

    // Round-robin priority moves just past the winner on each transfer.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            rr_ptr <= '0;
        end else if (mem_we) begin
            if (winner == IW'(NUM_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= winner + IW'(1);
            end
        end
    end

endmodule
